// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder backed by a word-organised SRAM, with a fixed number of wait states
// per OKAY transfer and a two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] ByteLimit = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WaitLast  = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          accept, illegal;
    logic [3:0]    lane_en;
    logic [31:0]   mem_q [MEM_WORDS];

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept  = HSEL && HREADY && HTRANS[1];
    assign illegal = (HSIZE > 3'd2)
                  || (HSIZE == 3'd1 && HADDR[0])
                  || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                  || ({1'b0, HADDR} >= ByteLimit);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        unique case (state_q)
            // Every state that shows HREADYOUT=1 may take the next address phase.
            StIdle, StData, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    addr_d  = HADDR[AW+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (illegal) begin
                        state_d = StErr1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StWait: begin
                if (cnt_q >= WaitLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        unique case (state_q)
            StWait: HREADYOUT = 1'b0;
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2: HRESP = 1'b1;
            StData: if (!write_q) HRDATA = mem_q[addr_q[AW+1:2]];
            default: ;
        endcase
    end

    // Little-endian byte lanes from the registered address and size.
    always_comb begin
        unique case (size_q)
            2'd0:    lane_en = 4'b0001 << addr_q[1:0];
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (state_q == StData && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem_q[addr_q[AW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder (slave) for the system bus; the target that answers our AHB-Lite master.
- Decodes address/control in the address phase and completes read/write data phases from an internal word-organised SRAM.
- Inserts a programmable number of wait states per transfer.
- Returns the two-cycle ERROR response for illegal accesses.

Parameters:
MEM_WORDS, 256, number of 32-bit words; byte address range 0 .. 4*MEM_WORDS-1 (power of two).
WAIT_CYCLES, 1, wait states inserted per OKAY transfer, legal range 0..14.

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset
HSEL  in  1  slave select from decoder
HADDR  in  32  byte address
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  0=byte, 1=halfword, 2=word
HBURST  in  3  burst type (ignored)
HPROT  in  4  protection (ignored)
HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HMASTLOCK  in  1  lock (ignored)
HREADY  in  1  bus-wide ready (previous transfer complete)
HWDATA  in  32  write data, valid in data phase
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
- SRAM contents are not reset.
- Reset mid-transfer aborts the transfer; no memory write occurs.
- Transfer accept: rising edge with HSEL && HREADY && HTRANS[1]=1.
  - Registers HADDR, HWRITE, HSIZE.
  - Other HTRANS values (IDLE, BUSY), or HSEL=0, give a zero-wait OKAY with no memory access.
- Illegal access, checked at accept. Any of:
  - HSIZE>2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR >= 4*MEM_WORDS.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept: go to WAIT if WAIT_CYCLES>0, else DATA. On an illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter counts 1..WAIT_CYCLES; after the WAIT_CYCLES-th cycle go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle. A new accept on the same edge is pipelined and handled as in IDLE; otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept on this edge is handled as in IDLE, so back-to-back transfers after an error are serviced.
- Data phase length: WAIT_CYCLES+1 cycles per OKAY transfer, 2 cycles per ERROR.
- Write:
  - Committed on the DATA-cycle rising edge using HWDATA.
  - Byte enables follow little-endian lanes from registered HADDR[1:0] and HSIZE:
    - byte: lane = addr[1:0];
    - halfword: lanes {addr[1],0}+0/1;
    - word: all four lanes.
  - Unselected lanes are unchanged.
- Read:
  - During the DATA cycle, HRDATA = full 32-bit word at mem[addr[log2(MEM_WORDS)+1:2]], with all lanes driven; the master selects the lanes.
  - HRDATA=0 in every other cycle and for writes and errors.
- Write-then-read of the same address in back-to-back pipelined transfers returns the new data. The write commits on the same edge the read is accepted, so the read data phase sees the updated memory.
- Address/control changes while HREADY=0 are ignored (no accept).

Test Plan:
- WAIT_CYCLES=1: word write 0xDEADBEEF @0x10, then read @0x10. Each transfer shows exactly one HREADYOUT=0 cycle, then HREADYOUT=1/HRESP=0; the read returns HRDATA=0xDEADBEEF.
- Byte write 0x55 @0x11 over 0xDEADBEEF, then halfword write 0x1234 @0x12. A word read @0x10 returns 0x123455EF.
- Word access @0x02, then access @0x400 with MEM_WORDS=256. Each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. Memory is unchanged and HRDATA=0.
- WAIT_CYCLES=0: 4-beat burst (NONSEQ+3 SEQ, one BUSY inserted) writing 1,2,3,4 @0x20..0x2C, then a read burst. No wait cycles; the BUSY beat gives an OKAY with no access; the reads return 1,2,3,4.
- HSEL=0 or HTRANS=IDLE with HWRITE=1 @0x10: HREADYOUT stays 1, HRESP=0, memory unchanged.
- Assert HRESETn=0 during a WAIT cycle of a write of 0xA5A5A5A5 @0x30. Outputs immediately return to HREADYOUT=1, HRESP=0, HRDATA=0; a later read @0x30 returns the pre-reset value.
